// File: rtl/bus_master_seq.sv
// Purpose : request-to-bus sequencer feeding the tristate bus buffer; turns
//           each accepted read/write into a timed strobe sequence on the
//           shared data bus and returns captured read data.
// Latency : write holds the bus for 2 cycles after acceptance; read data is
//           valid (rsp_valid pulse) 2 cycles after the acceptance edge.
// Backpressure: req_ready is high only in IDLE. Requests presented while it
//           is low are ignored, not queued. There is no response backpressure.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    request handshake; req_we, req_addr, req_wdata payload
//   rsp_valid, rsp_rdata   one-cycle read response pulse, held read data
//   bus_oe, bus_dout       drive enable and transmit data to the bus buffer
//   bus_din                receive data from the bus buffer
//   mem_addr, mem_we, mem_re  memory address and strobes
//   wr_cnt, rd_cnt         transaction counters, present only with BUS_MST_CNT_EN
// Optional feature macro: BUS_MST_CNT_EN

module bus_master_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bus_oe,
  output logic [DATA_WIDTH-1:0] bus_dout,
  input  logic [DATA_WIDTH-1:0] bus_din,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re
`ifdef BUS_MST_CNT_EN
  ,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           rd_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DRV  = 3'd1,
    WR_HOLD = 3'd2,
    RD_STB  = 3'd3,
    RD_CAP  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    bus_oe_q, bus_oe_d;
  logic [DATA_WIDTH-1:0]   bus_dout_q, bus_dout_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;
  logic                    accept;

  assign accept = req_valid && req_ready_q;

  // The output registers double as the request latches: mem_addr_q holds the
  // accepted address and bus_dout_q the accepted write data, while the
  // direction is remembered in the state itself.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    bus_dout_d  = bus_dout_q;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mem_addr_d = req_addr;
          if (req_we) begin
            state_d    = WR_DRV;
            bus_dout_d = req_wdata;
          end else begin
            state_d = RD_STB;
          end
        end
      end
      WR_DRV:  state_d = WR_HOLD;
      WR_HOLD: state_d = IDLE;
      RD_STB: begin
        // Memory drives bus_din combinationally while mem_re is high.
        state_d     = RD_CAP;
        rsp_rdata_d = bus_din;
      end
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they arrive registered in
    // the same cycle the state register enters that state.
    req_ready_d = (state_d == IDLE);
    bus_oe_d    = (state_d == WR_DRV) || (state_d == WR_HOLD);
    mem_we_d    = (state_d == WR_DRV);
    mem_re_d    = (state_d == RD_STB);
    rsp_valid_d = (state_d == RD_CAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_oe_q    <= 1'b0;
      bus_dout_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_oe_q    <= bus_oe_d;
      bus_dout_q  <= bus_dout_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_oe    = bus_oe_q;
  assign bus_dout  = bus_dout_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

`ifdef BUS_MST_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  // Counters advance on state entry; 16-bit addition wraps naturally.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if ((state_d == WR_DRV) && (state_q != WR_DRV)) wr_cnt_d = wr_cnt_q + 16'd1;
    if ((state_d == RD_CAP) && (state_q != RD_CAP)) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= 16'd0;
      rd_cnt_q <= 16'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_bus_master_seq.sv
// Bench for bus_master_seq: vector table of transactions, hand-written
// corner sequences, a small memory model on the bus, and a read-data
// scoreboard that is filled at request time and drained on rsp_valid.

module tb_bus_master_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       bus_oe;
  logic [7:0] bus_dout;
  logic [7:0] bus_din;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic       mem_re;
`ifdef BUS_MST_CNT_EN
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
`endif

  bus_master_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_oe    (bus_oe),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re)
`ifdef BUS_MST_CNT_EN
    ,
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: preloaded while in reset, written on mem_we with the bus
  // driven, drives the bus combinationally while mem_re is high.
  logic [7:0] mem [0:31];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 1);
      mem[31] <= 8'h3C;
    end else if (mem_we && bus_oe) begin
      mem[mem_addr] <= bus_dout;
    end
  end
  assign bus_din = bus_oe ? bus_dout : (mem_re ? mem[mem_addr] : 8'hEE);

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  logic prev_oe = 1'b0;
  logic prev_re = 1'b0;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; bus-wide invariants and response scoreboard are
  // evaluated at the falling edge of the cycle being left.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      check("no_contention", {31'd0, bus_oe && mem_re}, 32'd0);
      check("turnaround_gap", {31'd0, (prev_oe && mem_re) || (prev_re && bus_oe)}, 32'd0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, sb.pop_front()});
        end
      end
    end
    prev_oe = bus_oe;
    prev_re = mem_re;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (!we) sb.push_back(exp_rdata);
    tick();
    // Scramble the request inputs; the DUT must work from its latched copy.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (we) begin
      check("wr1_oe", bus_oe, 1);
      check("wr1_we", mem_we, 1);
      check("wr1_re", mem_re, 0);
      check("wr1_dout", bus_dout, wdata);
      check("wr1_addr", mem_addr, addr);
      check("wr1_ready", req_ready, 0);
      tick();
      check("wr2_oe", bus_oe, 1);
      check("wr2_we", mem_we, 0);
      check("wr2_dout", bus_dout, wdata);
      check("wr2_addr", mem_addr, addr);
      tick();
      check("wr3_ready", req_ready, 1);
      check("wr3_oe", bus_oe, 0);
    end else begin
      check("rd1_re", mem_re, 1);
      check("rd1_oe", bus_oe, 0);
      check("rd1_addr", mem_addr, addr);
      check("rd1_ready", req_ready, 0);
      check("rd1_rsp", rsp_valid, 0);
      tick();
      check("rd2_rsp", rsp_valid, 1);
      check("rd2_re", mem_re, 0);
      tick();
      check("rd3_ready", req_ready, 1);
      check("rd3_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    vecs[0] = '{we: 1'b1, addr: 5'h05, wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{we: 1'b0, addr: 5'h1F, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[2] = '{we: 1'b0, addr: 5'h05, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[3] = '{we: 1'b1, addr: 5'h00, wdata: 8'hFF, exp_rdata: 8'h00};
    vecs[4] = '{we: 1'b1, addr: 5'h1F, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[5] = '{we: 1'b0, addr: 5'h00, wdata: 8'h00, exp_rdata: 8'hFF};
    vecs[6] = '{we: 1'b0, addr: 5'h1F, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[7] = '{we: 1'b1, addr: 5'h0A, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[8] = '{we: 1'b0, addr: 5'h0A, wdata: 8'h00, exp_rdata: 8'h00};

    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    do_reset();

    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_dout", bus_dout, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      tick();
    end

    // Back-to-back: valid held high across a write then a read of addr 0.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h00; req_wdata = 8'h11;
    tick();
    req_we = 1'b0; req_wdata = 8'h00;
    check("b2b_c1_ready", req_ready, 0);
    check("b2b_c1_re", mem_re, 0);
    tick();
    check("b2b_c2_ready", req_ready, 0);
    check("b2b_c2_re", mem_re, 0);
    check("b2b_c2_oe", bus_oe, 1);
    tick();
    check("b2b_c3_ready", req_ready, 1);
    check("b2b_c3_oe", bus_oe, 0);
    check("b2b_c3_re", mem_re, 0);
    sb.push_back(8'h11);
    tick();
    req_valid = 1'b0;
    check("b2b_c4_re", mem_re, 1);
    tick();
    check("b2b_c5_rsp", rsp_valid, 1);
    tick();
    check("b2b_c6_ready", req_ready, 1);

    // Stall: a one-cycle read request during WR_HOLD must be dropped.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h03; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    check("stall_in_hold", mem_we == 1'b0 && bus_oe == 1'b1, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h03;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_re", mem_re, 0);
      check("stall_rsp", rsp_valid, 0);
      check("stall_ready", req_ready, 1);
      tick();
    end

    // Reset in the middle of WR_DRV: outputs clear without a clock edge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h1F; req_wdata = 8'hC3;
    tick();
    req_valid = 1'b0;
    check("mid_wr_drv_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_oe", bus_oe, 0);
    check("arst_we", mem_we, 0);
    check("arst_ready", req_ready, 1);
    check("arst_dout", bus_dout, 0);
    check("arst_addr", mem_addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset during RD_STB: the pending read must never respond.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h02;
    tick();
    req_valid = 1'b0;
    check("mid_rd_re", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_re", mem_re, 0);
    check("arst_rd_rsp", rsp_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("arst_rd_no_rsp", rsp_valid, 0);
      tick();
    end

`ifdef BUS_MST_CNT_EN
    do_reset();
    check("cnt_rst_wr", wr_cnt, 0);
    check("cnt_rst_rd", rd_cnt, 0);
    do_txn(1'b1, 5'h01, 8'h21, 8'h00);
    do_txn(1'b1, 5'h02, 8'h42, 8'h00);
    do_txn(1'b1, 5'h03, 8'h63, 8'h00);
    do_txn(1'b0, 5'h01, 8'h00, 8'h21);
    do_txn(1'b0, 5'h02, 8'h00, 8'h42);
    check("cnt_wr3", wr_cnt, 3);
    check("cnt_rd2", rd_cnt, 2);
    force dut.wr_cnt_q = 16'hFFFF;
    #1 release dut.wr_cnt_q;
    do_txn(1'b1, 5'h04, 8'h84, 8'h00);
    check("cnt_wr_wrap", wr_cnt, 0);
    force dut.rd_cnt_q = 16'hFFFF;
    #1 release dut.rd_cnt_q;
    do_txn(1'b0, 5'h03, 8'h00, 8'h63);
    check("cnt_rd_wrap", rd_cnt, 0);
`endif

    tick();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_seq.md
Name: bus_master_seq

Overview:
- Sequencer directly upstream of the tristate bus buffer. Accepts read/write requests over a valid/ready interface and converts each into a timed transaction on the shared bidirectional memory data bus.
- Produces the buffer's drive-enable and transmit data, and drives memory address and strobes.
- Captures receive data from the buffer on reads and returns it on a response interface.
- Guarantees no bus contention: at least one released-bus cycle between any two transactions.

Parameters:
- DATA_WIDTH, 8, data bus width in bits
- ADDR_WIDTH, 5, memory address width in bits

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  target address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle pulse, read data valid
- rsp_rdata  output  DATA_WIDTH  captured read data
- bus_oe  output  1  drive enable to the bus buffer (1 = drive the bus)
- bus_dout  output  DATA_WIDTH  transmit data to the bus buffer
- bus_din  input  DATA_WIDTH  receive data from the bus buffer
- mem_addr  output  ADDR_WIDTH  memory address
- mem_we  output  1  memory write strobe
- mem_re  output  1  memory read strobe; memory drives the bus combinationally while it is high

Behaviour:
- Single clock domain. rst_n is asynchronous assert, synchronous deassert (the source is responsible for the synchronizer). All outputs are registered.
- Reset values:
  - state = IDLE
  - req_ready = 1
  - rsp_valid = 0
  - rsp_rdata = 0
  - bus_oe = 0
  - bus_dout = 0
  - mem_addr = 0
  - mem_we = 0
  - mem_re = 0
- Handshake: a request is accepted on a clock edge where req_valid && req_ready. On acceptance, addr, we and wdata are latched into internal registers. The requester may change its inputs after acceptance.
- req_ready = 1 only in IDLE.
- FSM states: IDLE, WR_DRV, WR_HOLD, RD_STB, RD_CAP.
- IDLE:
  - bus_oe = 0, mem_we = 0, mem_re = 0.
  - On acceptance with req_we = 1 -> WR_DRV.
  - On acceptance with req_we = 0 -> RD_STB.
- WR_DRV (1 cycle):
  - bus_oe = 1, bus_dout = latched wdata, mem_addr = latched addr, mem_we = 1.
  - Next state: WR_HOLD.
- WR_HOLD (1 cycle):
  - bus_oe = 1, mem_we = 0; data and address held for hold time.
  - Next state: IDLE.
- RD_STB (1 cycle):
  - bus_oe = 0, mem_addr = latched addr, mem_re = 1.
  - At the end of this cycle, bus_din is sampled into rsp_rdata.
  - Next state: RD_CAP.
- RD_CAP (1 cycle):
  - mem_re = 0, rsp_valid = 1, rsp_rdata holds the captured value.
  - Next state: IDLE.
- rsp_rdata holds its value until the next read capture.
- Latency:
  - Write occupies 3 cycles including IDLE.
  - Read: rsp_valid asserts 2 cycles after the acceptance edge.
  - Maximum throughput is one transaction per 3 cycles.
- Contention rules (must hold in every cycle):
  - bus_oe and mem_re are never both 1.
  - Because every transaction returns through IDLE, every transition between driver and memory ownership of the bus passes through at least one cycle with bus_oe = 0 and mem_re = 0.
- Requests presented while req_ready = 0 are ignored, not queued. The requester must hold req_valid until accepted.
- Address boundaries: no wrap or range logic; all 2^ADDR_WIDTH addresses are legal (0 and 31 at default).
- Reset mid-transaction: all outputs return to reset values immediately and asynchronously. A write in WR_DRV is aborted (mem_we drops). A pending read produces no rsp_valid.

Optional Feature:
- Macro: BUS_MST_CNT_EN.
- When defined:
  - Two extra output ports: wr_cnt [15:0] and rd_cnt [15:0].
  - wr_cnt increments on entry to WR_DRV; rd_cnt increments on entry to RD_CAP.
  - Both wrap from 0xFFFF to 0x0000 and reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n = 0 mid-WR_DRV -> bus_oe = 0, mem_we = 0, req_ready = 1 immediately, with no clock edge required.
- Write: request we = 1, addr = 0x05, wdata = 0xA5 ->
  - Cycle +1: bus_oe = 1, mem_we = 1, bus_dout = 0xA5, mem_addr = 0x05.
  - Cycle +2: bus_oe = 1, mem_we = 0.
  - Cycle +3: IDLE, req_ready = 1.
- Read: model memory returns 0x3C on bus_din while mem_re = 1 at addr 0x1F ->
  - Cycle +1: mem_re = 1, bus_oe = 0.
  - Cycle +2: rsp_valid = 1, rsp_rdata = 0x3C.
- Back-to-back: write 0x11 to addr 0, then read addr 0 with req_valid held high continuously -> read is accepted only when req_ready = 1; assertion bus_oe && mem_re is never true; rsp_rdata = 0x11.
- Stall: req_valid pulsed for one cycle during WR_HOLD -> request ignored, no transaction, no rsp_valid.
- BUS_MST_CNT_EN: 3 writes and 2 reads -> wr_cnt = 3, rd_cnt = 2. Preload a counter to 0xFFFF via force, then complete one more transaction of that type -> counter = 0x0000.
